iq_avg_snapshot: RTL
====================

Name: iq_avg_snapshot

Overview:
- Parametrised successor to the averaged-IQ snapshot RAM path.
- Accepts a time-multiplexed stream of NUM_CH complex (I,Q) channels and averages 2^avg_log2 frames per channel.
- Writes one packed {Q,I} average per channel into the snapshot BRAM port A (bram_we/bram_en_a/bram_addr/bram_wr_data) until the buffer is full.
- Software arms it through a register and reads results through the BRAM's other port.

Parameters:
- NUM_CH, 4: channels per frame, ≥1.
- IN_W, 16: signed I and Q sample width; BRAM word is 2*IN_W.
- ADDR_W, 10: BRAM address width; capacity 2^ADDR_W words.
- MAX_LOG2, 8: largest averaging exponent; accumulator width is IN_W+MAX_LOG2.

Ports:
- clk  in  1  sample/BRAM clock.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse; starts or restarts a capture.
- avg_log2  in  $clog2(MAX_LOG2+1)  averaging exponent, latched on arm.
- in_valid  in  1  sample qualifier.
- in_sync  in  1  marks channel 0 of a frame; valid only with in_valid.
- in_i  in  IN_W  signed I.
- in_q  in  IN_W  signed Q.
- bram_we  out  1  BRAM port-A write strobe.
- bram_en_a  out  1  BRAM port-A enable; equals bram_we.
- bram_addr  out  ADDR_W  write address.
- bram_wr_data  out  2*IN_W  {Q_avg, I_avg}.
- busy  out  1  state is WAIT_SYNC or ACC.
- done  out  1  buffer full; sticky until next arm.
- sync_err  out  1  sticky; misaligned sync seen; cleared on arm.

Behaviour:
- Reset: all outputs 0; state IDLE; channel counter, frame counter and address cleared.
- States and transitions:
  - IDLE --arm--> WAIT_SYNC.
  - WAIT_SYNC --(in_valid & in_sync)--> ACC; that sample is channel 0, frame 0.
  - ACC --last write at address 2^ADDR_W-1--> DONE.
  - DONE --arm--> WAIT_SYNC.
  - arm in any state → WAIT_SYNC, with: addr=0, done=0, sync_err=0, avg_log2 latched (values > MAX_LOG2 clamped to MAX_LOG2).
- Channel index: increments on each valid sample and wraps NUM_CH-1→0; the frame counter increments on wrap.
- in_sync with channel index ≠ 0 (i.e. previous channel ≠ NUM_CH-1): set sync_err, force channel to 0, restart the frame counter at 0, and discard all partial accumulations (first-sample load semantics).
- Accumulate: in frame 0, acc[ch] = sign-extended sample; otherwise acc[ch] += sample. The I and Q accumulators are independent.
- At frame 2^L-1 (L = latched exponent): the result is (acc+sample) >>> L (arithmetic), truncated to IN_W.
  - Registered write 1 cycle after the sample: bram_we=1, bram_wr_data={Q,I}, bram_addr = current address.
  - Address increments after each write.
  - The frame counter then wraps to 0 after channel NUM_CH-1.
- L=0: every sample is written directly (pass-through snapshot).
- in_valid low: no state change; gaps are allowed anywhere.
- Write at address 2^ADDR_W-1: state → DONE, done=1 on the same cycle as that bram_we. No wrap-around; further samples are ignored.
- A partial frame at the moment of DONE is discarded.
- Reset mid-capture: immediate IDLE, and no write strobe is emitted.
- Throughput: one sample per clock, zero stall.

Optional Feature:
- Macro IQAVG_ROUND_EN.
- Defined: results are rounded half-up, i.e. (sum + 2^(L-1)) >>> L for L>0, then saturated to the signed IN_W range.
- Undefined: plain arithmetic-shift truncation, no saturation logic.

Decomposition:
- Package iq_avg_pkg holds:
  - state enum (IDLE, WAIT_SYNC, ACC, DONE);
  - ACC_W = IN_W+MAX_LOG2 function;
  - pack/unpack function for {Q,I} words.
- Sub-module iq_avg_acc_bank: NUM_CH × 2 accumulator registers with load/add select and registered shift/round output. The top-level holds the FSM, counters and BRAM port.

Test Plan:
1. NUM_CH=4, L=0, arm, then sync + 4 samples I=ch, Q=-ch → writes at addr 0..3 with data {-k,k}, each 1 cycle after its sample; busy=1.
2. L=2, 4 frames with ch0 I=1,2,3,6 → single write at addr 0, I=3; ch1 I=-1,-1,-1,-2 → I=-2 (truncation) or -1 (IQAVG_ROUND_EN).
3. ADDR_W=3, L=0, continuous stream → exactly 8 writes; done rises with the write at addr 7; following samples produce no bram_we.
4. Sync injected at channel 2 mid-frame → sync_err=1, no write for the broken frame, next aligned frame writes normally; arm clears sync_err.
5. Re-arm during ACC after 2 writes → next write lands at addr 0; rst asserted mid-frame → all outputs 0 immediately, no write.
6. in_valid gapped 1-in-3 with L=1 → results identical to the gap-free run.

Source files
------------

// File: rtl/iq_avg_pkg.sv
// Shared state encoding, accumulator sizing and {Q,I} word packing for the
// averaged-IQ snapshot path.
package iq_avg_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    ACC       = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Widest sample the pack/unpack helpers can carry per component.
  localparam int PACK_MAX_W = 32;

  function automatic int acc_w(input int in_w, input int max_log2);
    return in_w + max_log2;
  endfunction

  function automatic logic [2*PACK_MAX_W-1:0] pack_iq(input logic [PACK_MAX_W-1:0] i_val,
                                                      input logic [PACK_MAX_W-1:0] q_val,
                                                      input int w);
    logic [2*PACK_MAX_W-1:0] mask_v;
    mask_v = (64'd1 << w) - 64'd1;
    return ({{PACK_MAX_W{1'b0}}, i_val} & mask_v) | (({{PACK_MAX_W{1'b0}}, q_val} & mask_v) << w);
  endfunction

  function automatic logic [PACK_MAX_W-1:0] unpack_i(input logic [2*PACK_MAX_W-1:0] word, input int w);
    logic [2*PACK_MAX_W-1:0] mask_v;
    mask_v = (64'd1 << w) - 64'd1;
    return PACK_MAX_W'(word & mask_v);
  endfunction

  function automatic logic [PACK_MAX_W-1:0] unpack_q(input logic [2*PACK_MAX_W-1:0] word, input int w);
    logic [2*PACK_MAX_W-1:0] mask_v;
    mask_v = (64'd1 << w) - 64'd1;
    return PACK_MAX_W'((word >> w) & mask_v);
  endfunction

endpackage

// File: rtl/iq_avg_acc_bank.sv
// Per-channel I/Q accumulators with load/add select and a registered scaled output.
// IQAVG_ROUND_EN selects round-half-up with saturation instead of plain truncation.
module iq_avg_acc_bank
  import iq_avg_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int IN_W     = 16,
  parameter int MAX_LOG2 = 8,
  parameter int CH_W     = 2,
  parameter int LW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_en,
  input  logic [CH_W-1:0] ch,
  input  logic            first,
  input  logic            last,
  input  logic [LW-1:0]   shift,
  input  logic [IN_W-1:0] in_i,
  input  logic [IN_W-1:0] in_q,
  output logic            out_valid,
  output logic [IN_W-1:0] out_i,
  output logic [IN_W-1:0] out_q
);

  localparam int ACC_W = acc_w(IN_W, MAX_LOG2);

`ifdef IQAVG_ROUND_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'({1'b0, {(IN_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
`endif

  logic signed [ACC_W-1:0] acc_i_r [NUM_CH];
  logic signed [ACC_W-1:0] acc_q_r [NUM_CH];
  logic signed [ACC_W-1:0] sum_i_s;
  logic signed [ACC_W-1:0] sum_q_s;
  logic                    out_valid_r;
  logic [IN_W-1:0]         out_i_r;
  logic [IN_W-1:0]         out_q_r;

  function automatic logic [IN_W-1:0] scale(input logic signed [ACC_W-1:0] sum_v,
                                            input logic [LW-1:0] sh);
`ifdef IQAVG_ROUND_EN
    logic signed [ACC_W-1:0] res_v;
    if (sh != {LW{1'b0}}) begin
      res_v = sum_v + (ACC_W'(1'b1) << (sh - LW'(1'b1)));
    end else begin
      res_v = sum_v;
    end
    res_v = res_v >>> sh;
    if (res_v > SAT_HI) begin
      return IN_W'(SAT_HI);
    end else if (res_v < SAT_LO) begin
      return IN_W'(SAT_LO);
    end else begin
      return IN_W'(res_v);
    end
`else
    return IN_W'(sum_v >>> sh);
`endif
  endfunction

  // First frame of a block loads the sample; later frames add to the running sum.
  always_comb begin
    sum_i_s = ACC_W'(signed'(in_i));
    sum_q_s = ACC_W'(signed'(in_q));
    if (first) begin
      sum_i_s = ACC_W'(signed'(in_i));
      sum_q_s = ACC_W'(signed'(in_q));
    end else begin
      sum_i_s = acc_i_r[ch] + ACC_W'(signed'(in_i));
      sum_q_s = acc_q_r[ch] + ACC_W'(signed'(in_q));
    end
  end

  // Accumulator storage and the registered average emitted on the block's last frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        acc_i_r[k] <= {ACC_W{1'b0}};
        acc_q_r[k] <= {ACC_W{1'b0}};
      end
      out_valid_r <= 1'b0;
      out_i_r     <= {IN_W{1'b0}};
      out_q_r     <= {IN_W{1'b0}};
    end else begin
      out_valid_r <= sample_en && last;
      if (sample_en && last) begin
        out_i_r <= scale(sum_i_s, shift);
        out_q_r <= scale(sum_q_s, shift);
      end else if (sample_en) begin
        acc_i_r[ch] <= sum_i_s;
        acc_q_r[ch] <= sum_q_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_i     = out_i_r;
  assign out_q     = out_q_r;

endmodule

// File: rtl/iq_avg_snapshot.sv
// Averaged-IQ snapshot writer: capture FSM, channel/frame/address counters and BRAM port A.
// Define IQAVG_ROUND_EN for round-half-up with saturation of the averages.
module iq_avg_snapshot
  import iq_avg_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int IN_W     = 16,
  parameter int ADDR_W   = 10,
  parameter int MAX_LOG2 = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm,
  input  logic [$clog2(MAX_LOG2+1)-1:0] avg_log2,
  input  logic                         in_valid,
  input  logic                         in_sync,
  input  logic [IN_W-1:0]              in_i,
  input  logic [IN_W-1:0]              in_q,
  output logic                         bram_we,
  output logic                         bram_en_a,
  output logic [ADDR_W-1:0]            bram_addr,
  output logic [2*IN_W-1:0]            bram_wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         sync_err
);

  localparam int LW   = $clog2(MAX_LOG2+1);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FR_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [LW-1:0]     L_MAX     = LW'(MAX_LOG2);

  state_t            state_r;
  logic [CH_W-1:0]   ch_r, ch_eff_s, ch_next_s;
  logic [FR_W-1:0]   frame_r, frame_eff_s, frame_next_s, frame_last_s;
  logic [FR_W:0]     frame_span_s;
  logic [ADDR_W-1:0] addr_r, bram_addr_r;
  logic [LW-1:0]     avg_l_r;
  logic              busy_r, done_r, sync_err_r;
  logic              sample_s, misalign_s, first_s, last_s, write_s;
  logic              wr_valid_s;
  logic [IN_W-1:0]   wr_i_s, wr_q_s;

  // Effective channel/frame of the incoming sample and the counter values that follow it.
  always_comb begin
    sample_s     = 1'b0;
    misalign_s   = (state_r == ACC) && in_sync && (ch_r != {CH_W{1'b0}});
    ch_eff_s     = ch_r;
    frame_eff_s  = frame_r;
    ch_next_s    = ch_r;
    frame_next_s = frame_r;
    if (state_r == WAIT_SYNC) begin
      sample_s = in_valid && in_sync && !arm;
    end else if (state_r == ACC) begin
      sample_s = in_valid && !arm;
    end else begin
      sample_s = 1'b0;
    end
    // A sync away from channel 0 restarts the frame and drops partial sums.
    if (misalign_s) begin
      ch_eff_s    = {CH_W{1'b0}};
      frame_eff_s = {FR_W{1'b0}};
    end else begin
      ch_eff_s    = ch_r;
      frame_eff_s = frame_r;
    end
    frame_span_s = (FR_W+1)'(1'b1) << avg_l_r;
    frame_last_s = FR_W'(frame_span_s - (FR_W+1)'(1'b1));
    first_s      = (frame_eff_s == {FR_W{1'b0}});
    last_s       = (frame_eff_s == frame_last_s);
    write_s      = sample_s && last_s;
    if (ch_eff_s == CH_LAST) begin
      ch_next_s    = {CH_W{1'b0}};
      frame_next_s = last_s ? {FR_W{1'b0}} : frame_eff_s + FR_W'(1'b1);
    end else begin
      ch_next_s    = ch_eff_s + CH_W'(1'b1);
      frame_next_s = frame_eff_s;
    end
  end

  // Capture FSM with counters and registered status/address outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ch_r        <= {CH_W{1'b0}};
      frame_r     <= {FR_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      bram_addr_r <= {ADDR_W{1'b0}};
      avg_l_r     <= {LW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sync_err_r  <= 1'b0;
    end else if (arm) begin
      state_r    <= WAIT_SYNC;
      ch_r       <= {CH_W{1'b0}};
      frame_r    <= {FR_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      avg_l_r    <= (avg_log2 > L_MAX) ? L_MAX : avg_log2;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          state_r <= state_r;
        end
        WAIT_SYNC, ACC: begin
          if (sample_s) begin
            state_r <= ACC;
            ch_r    <= ch_next_s;
            frame_r <= frame_next_s;
            if (misalign_s) begin
              sync_err_r <= 1'b1;
            end
            if (write_s) begin
              bram_addr_r <= addr_r;
              // The buffer never wraps: the top address ends the capture.
              if (addr_r == ADDR_LAST) begin
                state_r <= DONE;
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
              end else begin
                addr_r <= addr_r + ADDR_W'(1'b1);
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  iq_avg_acc_bank #(
    .NUM_CH   (NUM_CH),
    .IN_W     (IN_W),
    .MAX_LOG2 (MAX_LOG2),
    .CH_W     (CH_W),
    .LW       (LW)
  ) u_acc_bank (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_s),
    .ch        (ch_eff_s),
    .first     (first_s),
    .last      (last_s),
    .shift     (avg_l_r),
    .in_i      (in_i),
    .in_q      (in_q),
    .out_valid (wr_valid_s),
    .out_i     (wr_i_s),
    .out_q     (wr_q_s)
  );

  assign bram_we      = wr_valid_s;
  assign bram_en_a    = wr_valid_s;
  assign bram_addr    = bram_addr_r;
  assign bram_wr_data = (2*IN_W)'(pack_iq(PACK_MAX_W'(wr_i_s), PACK_MAX_W'(wr_q_s), IN_W));
  assign busy         = busy_r;
  assign done         = done_r;
  assign sync_err     = sync_err_r;

endmodule
